// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4)+parity (SECDED byte) definitions for the encoder and the decoder side.
// Latency: not applicable (types, constants and a pure combinational function).
// Backpressure: not applicable.
//
// Contents: CW_W/FRAME_W widths, tx_state_t for the UART transmitter FSM,
// hamming74_secded() which maps a 4-bit message to the 8-bit frame byte.
package hamming_pkg;

    localparam int CW_W    = 7;   // Hamming(7,4) codeword width
    localparam int FRAME_W = 8;   // codeword plus overall even-parity bit

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Bit order matches the decoder: c0/c1/c3 are the check bits at Hamming
    // positions 1/2/4, data bits sit at positions 3/5/6/7. c7 makes the whole
    // byte even parity so the receiver can tell single from double errors.
    function automatic logic [FRAME_W-1:0] hamming74_secded(input logic [3:0] d);
        logic [CW_W-1:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return {^c, c};
    endfunction

endpackage

// File: rtl/hamming_uart_tx_if.sv
// Switch-side request bundle and UART-side status for hamming_uart_tx.
// Latency: not applicable (wiring only).
// Backpressure: send is a level request, honoured only while the transmitter is idle.
//
// Signals: data_in[3:0], send (to transmitter); tx, busy, done (from transmitter).
// With HAMMING_ERR_INJECT_EN defined, err_en and err_pos[2:0] are also carried.
// master = switch/stimulus side, slave = transmitter.
interface hamming_uart_tx_if;

    logic [3:0] data_in;
    logic       send;
    logic       tx;
    logic       busy;
    logic       done;
`ifdef HAMMING_ERR_INJECT_EN
    logic       err_en;
    logic [2:0] err_pos;

    modport master (output data_in, send, err_en, err_pos, input tx, busy, done);
    modport slave  (input data_in, send, err_en, err_pos, output tx, busy, done);
`else
    modport master (output data_in, send, input tx, busy, done);
    modport slave  (input data_in, send, output tx, busy, done);
`endif

endinterface

// File: rtl/hamming_enc.sv
// Combinational 4-bit message to 8-bit SECDED frame byte encoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
//
// Ports: d[3:0] message in, c[7:0] frame byte out.
module hamming_enc
    import hamming_pkg::*;
(
    input  logic [3:0]         d,
    output logic [FRAME_W-1:0] c
);

    assign c = hamming74_secded(d);

endmodule

// File: rtl/hamming_uart_tx.sv
// Encodes a 4-bit switch message as a SECDED byte and sends it as one UART 8N1 frame, LSB first.
// Latency: tx start bit on the cycle after accept; frame lasts 10*CLKS_PER_BIT cycles, done one cycle later.
// Backpressure: send is only honoured in IDLE; requests while busy are dropped, a held send repeats frames.
//
// Ports: clk, rst_n (synchronous, active low), bus (hamming_uart_tx_if.slave:
// data_in, send, tx, busy, done; plus err_en, err_pos when built with
// HAMMING_ERR_INJECT_EN, which inverts one frame-byte bit after parity).
module hamming_uart_tx
    import hamming_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic             clk,
    input  logic             rst_n,
    hamming_uart_tx_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("hamming_uart_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    logic [FRAME_W-1:0] enc_byte;
    logic [FRAME_W-1:0] frame_byte;

    hamming_enc u_enc (
        .d (bus.data_in),
        .c (enc_byte)
    );

`ifdef HAMMING_ERR_INJECT_EN
    // Flip is applied after parity, so pos 7 corrupts the parity bit itself.
    assign frame_byte = bus.err_en ? (enc_byte ^ (FRAME_W'(1) << bus.err_pos)) : enc_byte;
`else
    assign frame_byte = enc_byte;
`endif

    tx_state_t          state;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [2:0]         bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic               tx_q;
    logic               busy_q;
    logic               done_q;
    logic               baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    baud_cnt <= '0;
                    if (bus.send) begin
                        shreg   <= frame_byte;
                        bit_cnt <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx_q     <= shreg[0];
                        shreg    <= {1'b0, shreg[FRAME_W-1:1]};
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            // bit_cnt parks at 7 until the next accept
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_q    <= shreg[0];
                            shreg   <= {1'b0, shreg[FRAME_W-1:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Directed bench for hamming_uart_tx with a frame scoreboard and SECDED decoder model.
// Latency: CLKS_PER_BIT=16, so a frame spans cycles 1..160 after the accept cycle, done at 161.
// Backpressure: exercises dropped mid-frame requests and back-to-back frames from a held send.
module tb_hamming_uart_tx;

    localparam int FRAME_CYC = 161;   // accept-to-next-accept period for a held send

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hamming_uart_tx_if bus ();

    hamming_uart_tx #(
        .CLK_FREQ_HZ (16),
        .BAUD_RATE   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] d;      // message expected after decoding
        logic [7:0] b;      // expected raw frame byte
        bit         chkb;   // compare raw byte
        bit         err;    // decoder should report a corrected error
    } exp_t;

    exp_t qexp[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver-side SECDED model: returns {error_seen, corrected data}.
    function automatic logic [4:0] decode(input logic [7:0] c);
        logic [2:0] syn;
        logic [7:0] x;
        logic       p;
        syn[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        syn[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        syn[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        p = ^c;
        x = c;
        if (syn != 3'd0) x[syn - 3'd1] = ~x[syn - 3'd1];
        return {(syn != 3'd0) || p, x[6], x[5], x[4], x[2]};
    endfunction

    function automatic exp_t mk(input logic [3:0] d, input logic [7:0] b, input bit chkb, input bit err);
        exp_t e;
        e.d = d; e.b = b; e.chkb = chkb; e.err = err;
        return e;
    endfunction

    // Steps `total` cycles after an accept cycle, sampling tx at mid-bit of
    // each of `nframes` frames spaced FRAME_CYC apart, and tracking done/busy.
    task automatic watch(input int total, input int nframes, input int drop_at, input int pulse_at,
                         output int done_cnt, output int first_done, output int last_done,
                         output int busy_lo, output int idle_bad);
        logic [7:0] b;
        logic [4:0] dec;
        exp_t       e;
        int         rel;
        done_cnt = 0; first_done = -1; last_done = -1; busy_lo = 0; idle_bad = 0; b = '0;
        for (int n = 1; n <= total; n++) begin
            @(posedge clk); #1;
            if (n == drop_at) begin
                bus.send    = 1'b0;
                bus.data_in = ~bus.data_in;
            end
            if (pulse_at > 0 && n == pulse_at)     bus.send = 1'b1;
            if (pulse_at > 0 && n == pulse_at + 1) bus.send = 1'b0;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
                last_done = n;
            end
            rel = n % FRAME_CYC;
            if (n <= nframes * FRAME_CYC) begin
                if (rel >= 1 && bus.busy !== 1'b1) busy_lo++;
                if (rel == 1) chk("start_edge", 32'(bus.tx), 32'd0);
                if (rel == 8) chk("start_mid", 32'(bus.tx), 32'd0);
                if (rel >= 24 && rel <= 136 && (rel - 24) % 16 == 0) b[(rel - 24) / 16] = bus.tx;
                if (rel == 152) begin
                    chk("stop_bit", 32'(bus.tx), 32'd1);
                    chk("sb_pending", 32'(qexp.size() != 0), 32'd1);
                    if (qexp.size() != 0) begin
                        e = qexp.pop_front();
                        if (e.chkb) chk("frame_byte", 32'(b), 32'(e.b));
                        dec = decode(b);
                        chk("decoded_data", 32'(dec[3:0]), 32'(e.d));
                        chk("decoder_err", 32'(dec[4]), 32'(e.err));
                    end
                end
            end else if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
                idle_bad++;
            end
        end
    endtask

    initial begin
        int dc, fd, ld, bl, ib, bad;
        rst_n       = 1'b0;
        bus.send    = 1'b0;
        bus.data_in = 4'h0;
`ifdef HAMMING_ERR_INJECT_EN
        bus.err_en  = 1'b0;
        bus.err_pos = 3'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", 32'(bus.tx), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_tx", 32'(bus.tx), 32'd1);

        // 1: single frame of 4'b1011
        bus.data_in = 4'b1011;
        qexp.push_back(mk(4'b1011, 8'h55, 1'b1, 1'b0));
        bus.send = 1'b1;
        chk("accept_cycle_tx", 32'(bus.tx), 32'd1);
        watch(FRAME_CYC + 10, 1, 1, 0, dc, fd, ld, bl, ib);
        chk("t1_done_cnt", 32'(dc), 32'd1);
        chk("t1_done_cycle", 32'(fd), 32'd161);
        chk("t1_busy_gap", 32'(bl), 32'd0);
        chk("t1_idle", 32'(ib), 32'd0);

        // 2: encode sweep; data_in toggles mid-frame each time
        for (int d = 0; d < 16; d++) begin
            bus.data_in = 4'(d);
            case (d)
                0:       qexp.push_back(mk(4'h0, 8'h00, 1'b1, 1'b0));
                1:       qexp.push_back(mk(4'h1, 8'h87, 1'b1, 1'b0));
                15:      qexp.push_back(mk(4'hF, 8'hFF, 1'b1, 1'b0));
                default: qexp.push_back(mk(4'(d), 8'h00, 1'b0, 1'b0));
            endcase
            bus.send = 1'b1;
            watch(FRAME_CYC + 2, 1, 1, 0, dc, fd, ld, bl, ib);
            chk("t2_done_cnt", 32'(dc), 32'd1);
        end

        // 3: send pulsed mid-frame is dropped
        bus.data_in = 4'h1;
        qexp.push_back(mk(4'h1, 8'h87, 1'b1, 1'b0));
        bus.send = 1'b1;
        watch(FRAME_CYC + 30, 1, 1, 40, dc, fd, ld, bl, ib);
        chk("t3_done_cnt", 32'(dc), 32'd1);
        chk("t3_busy_gap", 32'(bl), 32'd0);
        chk("t3_no_second", 32'(ib), 32'd0);

        // 4: held send gives back-to-back frames
        bus.data_in = 4'h1;
        qexp.push_back(mk(4'h1, 8'h87, 1'b1, 1'b0));
        qexp.push_back(mk(4'h1, 8'h87, 1'b1, 1'b0));
        bus.send = 1'b1;
        watch(2 * FRAME_CYC + 20, 2, FRAME_CYC + 1, 0, dc, fd, ld, bl, ib);
        chk("t4_done_cnt", 32'(dc), 32'd2);
        chk("t4_done_first", 32'(fd), 32'd161);
        chk("t4_done_second", 32'(ld), 32'd322);
        chk("t4_busy_gap", 32'(bl), 32'd0);
        chk("t4_idle", 32'(ib), 32'd0);

        // 5: reset mid-frame aborts without done
        bus.data_in = 4'h6;
        bus.send = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus.send = 1'b0;
        end
        chk("t5_pre_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t5_abort_tx", 32'(bus.tx), 32'd1);
        chk("t5_abort_busy", 32'(bus.busy), 32'd0);
        chk("t5_abort_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 180; n++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        chk("t5_quiet", 32'(bad), 32'd0);
        bus.data_in = 4'h2;
        qexp.push_back(mk(4'h2, 8'h99, 1'b1, 1'b0));
        bus.send = 1'b1;
        watch(FRAME_CYC + 10, 1, 1, 0, dc, fd, ld, bl, ib);
        chk("t5_done_cnt", 32'(dc), 32'd1);
        chk("t5_done_cycle", 32'(fd), 32'd161);

`ifdef HAMMING_ERR_INJECT_EN
        // 6: single-bit injection, corrected by the decoder model
        bus.data_in = 4'b1011;
        bus.err_en  = 1'b1;
        bus.err_pos = 3'd3;
        qexp.push_back(mk(4'b1011, 8'h5D, 1'b1, 1'b1));
        bus.send = 1'b1;
        watch(FRAME_CYC + 2, 1, 1, 0, dc, fd, ld, bl, ib);
        chk("t6_done_cnt", 32'(dc), 32'd1);
        bus.data_in = 4'b1011;
        bus.err_en  = 1'b0;
        qexp.push_back(mk(4'b1011, 8'h55, 1'b1, 1'b0));
        bus.send = 1'b1;
        watch(FRAME_CYC + 2, 1, 1, 0, dc, fd, ld, bl, ib);
        chk("t6_clean_done", 32'(dc), 32'd1);
`endif

        chk("sb_empty", 32'(qexp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
